// File: rtl/bit_packer_if.sv
// Field-in / word-out bundle of the bit packer.
interface bit_packer_if;
   logic        pushin;
   logic [3:0]  lenin;
   logic [14:0] datain;
   logic        flush;
   logic        pushout;
   logic [31:0] dataout;
   logic [5:0]  fill;

   // Producer of fields and consumer of words
   modport master (
      output pushin, lenin, datain, flush,
      input  pushout, dataout, fill
   );

   // The packer itself
   modport slave (
      input  pushin, lenin, datain, flush,
      output pushout, dataout, fill
   );
endinterface

// File: rtl/bit_packer.sv
// Packs variable-length fields (0..15 bits) MSB-first into 32-bit words, with padded flush.
module bit_packer #(
   parameter logic PAD_BIT = 1'b0
) (
   input logic          i_clock,
   input logic          i_reset,
   bit_packer_if.slave  io_bus
);

   typedef enum logic {StAcc, StFlush2} state_e;

   // Held bits are left-aligned at r_acc[46]; 31 residue + 15 new bits never exceed 47.
   state_e      r_state;
   logic [46:0] r_acc;
   logic [5:0]  r_fill;
   logic        r_pushout;
   logic [31:0] r_dataout;

   state_e      w_state_nxt;
   logic [46:0] w_acc_nxt;
   logic [5:0]  w_fill_nxt;
   logic        w_pushout_nxt;
   logic [31:0] w_dataout_nxt;

   logic [3:0]  w_len;
   logic [46:0] w_field;
   logic [46:0] w_base_acc;
   logic [5:0]  w_base_fill;
   logic [6:0]  w_shift;
   logic [46:0] w_cat;
   logic [5:0]  w_cnt;
   logic [46:0] w_rem_acc;
   logic [5:0]  w_rem_fill;

   // Top n bits of acc kept, the rest forced to PAD_BIT
   function automatic logic [31:0] pad_word(input logic [46:0] acc, input logic [5:0] n);
      logic [31:0] keep;
      keep = ~(32'hFFFF_FFFF >> n);
      return (acc[46:15] & keep) | ({32{PAD_BIT}} & ~keep);
   endfunction

   // Append the masked field after the held bits; in FLUSH2 the remainder leaves first
   always_comb begin
      w_len       = io_bus.pushin ? io_bus.lenin : 4'd0;
      w_field     = {32'd0, io_bus.datain} & ((47'd1 << w_len) - 47'd1);
      w_base_acc  = (r_state == StFlush2) ? 47'd0 : r_acc;
      w_base_fill = (r_state == StFlush2) ? 6'd0 : r_fill;
      w_shift     = 7'd47 - {1'b0, w_base_fill} - {3'd0, w_len};
      w_cat       = w_base_acc | (w_field << w_shift);
      w_cnt       = w_base_fill + {2'd0, w_len};
      w_rem_acc   = w_cat << 32;
      w_rem_fill  = w_cnt - 6'd32;
   end

   // Next-state and word emission
   always_comb begin
      w_state_nxt   = StAcc;
      w_acc_nxt     = w_cat;
      w_fill_nxt    = w_cnt;
      w_pushout_nxt = 1'b0;
      w_dataout_nxt = r_dataout;
      unique case (r_state)
         StFlush2: begin
            // Flush input is ignored here; a field restarts from an empty accumulator
            w_pushout_nxt = 1'b1;
            w_dataout_nxt = pad_word(r_acc, r_fill);
         end
         default: begin
            if (w_cnt >= 6'd32) begin
               w_pushout_nxt = 1'b1;
               w_dataout_nxt = w_cat[46:15];
               w_acc_nxt     = w_rem_acc;
               w_fill_nxt    = w_rem_fill;
               if (io_bus.flush && (w_rem_fill != 6'd0)) begin
                  w_state_nxt = StFlush2;
               end
            end else if (io_bus.flush && (w_cnt != 6'd0)) begin
               w_pushout_nxt = 1'b1;
               w_dataout_nxt = pad_word(w_cat, w_cnt);
               w_acc_nxt     = 47'd0;
               w_fill_nxt    = 6'd0;
            end
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state   <= StAcc;
         r_acc     <= 47'd0;
         r_fill    <= 6'd0;
         r_pushout <= 1'b0;
         r_dataout <= 32'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_acc     <= w_acc_nxt;
         r_fill    <= w_fill_nxt;
         r_pushout <= w_pushout_nxt;
         r_dataout <= w_dataout_nxt;
      end
   end

   assign io_bus.pushout = r_pushout;
   assign io_bus.dataout = r_dataout;
   assign io_bus.fill    = r_fill;

endmodule

// File: tb/tb_bit_packer.sv
// Scoreboard bench for bit_packer: bit-queue reference model, randomized and directed traffic.
module tb_bit_packer;

   localparam logic PAD = 1'b0;

   typedef struct {
      logic        push;
      logic [31:0] word;
      logic [5:0]  fill;
   } exp_t;

   logic clk;
   logic rst;
   bit_packer_if bus();

   bit_packer #(.PAD_BIT(PAD)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .io_bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   // Reference model state: held bits in arrival order, plus a pending padded remainder
   bit          hq[$];
   bit          pend;
   logic [31:0] last_word;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] take_padded();
      logic [31:0] w;
      for (int i = 0; i < 32; i++) w[31-i] = (i < hq.size()) ? hq[i] : PAD;
      hq.delete();
      return w;
   endfunction

   // One clock of stimulus; the model's expected response is queued for the monitor
   task automatic cyc(input logic r, input logic p, input logic [3:0] l,
                      input logic [14:0] d, input logic f);
      exp_t e;
      bit   emitted;
      @(negedge clk);
      rst = r; bus.pushin = p; bus.lenin = l; bus.datain = d; bus.flush = f;
      emitted = 0;
      if (r) begin
         hq.delete(); pend = 0; last_word = 32'd0;
      end else begin
         if (pend) begin
            last_word = take_padded(); emitted = 1; pend = 0;
         end
         if (p) for (int i = int'(l) - 1; i >= 0; i--) hq.push_back(d[i]);
         if (!emitted && hq.size() >= 32) begin
            for (int i = 0; i < 32; i++) last_word[31-i] = hq.pop_front();
            emitted = 1;
            if (f && hq.size() > 0) pend = 1;
         end else if (!emitted && f && hq.size() > 0) begin
            last_word = take_padded(); emitted = 1;
         end
      end
      e.push = emitted; e.word = last_word; e.fill = 6'(hq.size());
      sb.push_back(e);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 4'd0, 15'd0, 1'b0);
   endtask

   // Monitor: one expected entry per clock, compared just after the edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("pushout", {31'd0, bus.pushout}, {31'd0, e.push});
         chk("dataout", bus.dataout, e.word);
         chk("fill", {26'd0, bus.fill}, {26'd0, e.fill});
      end
   end

   task automatic eight_nibbles();
      for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, 4'd4, 15'(i), 1'b0);
   endtask

   task automatic direct(input string name, input logic [31:0] exp_word, input logic [5:0] exp_fill);
      @(posedge clk); #2;
      chk({name, "_push"}, {31'd0, bus.pushout}, 32'd1);
      chk({name, "_word"}, bus.dataout, exp_word);
      chk({name, "_fill"}, {26'd0, bus.fill}, {26'd0, exp_fill});
   endtask

   initial begin
      rst = 1'b1; bus.pushin = 1'b0; bus.lenin = 4'd0; bus.datain = 15'd0; bus.flush = 1'b0;
      pend = 0; last_word = 32'd0;
      repeat (2) cyc(1'b1, 1'b0, 4'd0, 15'd0, 1'b0);

      // Eight nibbles form one word
      eight_nibbles();
      direct("nibbles", 32'h1234_5678, 6'd0);

      // 15+15+2 bits of ones
      cyc(1'b0, 1'b1, 4'd15, 15'h7FFF, 1'b0);
      cyc(1'b0, 1'b1, 4'd15, 15'h7FFF, 1'b0);
      cyc(1'b0, 1'b1, 4'd2, 15'h7FFF, 1'b0);
      direct("ones32", 32'hFFFF_FFFF, 6'd0);

      // 45 bits then flush
      repeat (3) cyc(1'b0, 1'b1, 4'd15, 15'h7FFF, 1'b0);
      direct("ones45", 32'hFFFF_FFFF, 6'd13);
      cyc(1'b0, 1'b0, 4'd0, 15'd0, 1'b1);
      direct("flush13", 32'hFFF8_0000, 6'd0);

      // Push with flush, then a lone flush with nothing held
      cyc(1'b0, 1'b1, 4'd4, 15'h7FFA, 1'b1);
      direct("pushflush", 32'hA000_0000, 6'd0);
      cyc(1'b0, 1'b0, 4'd0, 15'd0, 1'b1);
      idle();

      // fill=20 then len15+flush: full word, then padded 3-bit remainder
      cyc(1'b0, 1'b1, 4'd15, 15'h1234, 1'b0);
      cyc(1'b0, 1'b1, 4'd5, 15'h0015, 1'b0);
      cyc(1'b0, 1'b1, 4'd15, 15'h5A5A, 1'b1);
      cyc(1'b0, 1'b1, 4'd3, 15'h0005, 1'b1);
      idle(); idle();

      // fill=20, reset mid-word, then the nibble pattern again with lenin=0 pushes mixed in
      cyc(1'b0, 1'b1, 4'd15, 15'h7FFF, 1'b0);
      cyc(1'b0, 1'b1, 4'd5, 15'h001F, 1'b0);
      cyc(1'b1, 1'b1, 4'd4, 15'h000F, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 1'b1, 4'd0, 15'h7FFF, 1'b0);
         cyc(1'b0, 1'b1, 4'd4, 15'(i), 1'b0);
      end
      direct("after_reset", 32'h1234_5678, 6'd0);

      // Randomized traffic with garbage above lenin
      for (int n = 0; n < 3000; n++) begin
         logic r, p, f;
         r = ($urandom_range(0, 199) == 0);
         p = ($urandom_range(0, 9) < 7);
         f = ($urandom_range(0, 9) == 0);
         cyc(r, p, 4'($urandom_range(0, 15)), 15'($urandom), f);
      end
      repeat (3) idle();
      @(posedge clk); #3;
      chk("sb_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 Parameter: PAD_BIT, default 1'b0, value used to fill unused low bits of a word emitted by flush.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pushin  input  1  field valid this cycle.
REQ-005 lenin  input  4  field length in bits, 0..15; 0 = no-op.
REQ-006 datain  input  15  field value, right-justified in datain[lenin-1:0]; bits at or above lenin ignored.
REQ-007 flush  input  1  pad the partial word to 32 bits and emit it.
REQ-008 pushout  output  1  dataout valid this cycle; one-cycle pulse per word; feeds downstream pushin.
REQ-009 dataout  output  32  packed word; earliest bit in dataout[31].
REQ-010 fill  output  6  bits currently held and not yet emitted, 0..31 after each update.

Function
REQ-011 Packing order SHALL be MSB-first: field bit lenin-1 is placed before field bit 0; a later field follows an earlier field contiguously, with no gaps.
REQ-012 Accumulator SHALL be at least 47 bits wide plus a 6-bit count; worst case is 31 residue + 15 new = 46 bits, so no overflow is possible.
REQ-013 On pushin=1 and lenin>0: count_next = fill + lenin; the field is appended after the held bits.
REQ-014 If count_next >= 32: the first 32 bits SHALL appear on dataout with pushout=1 on the next cycle (registered, latency 1 cycle from the completing pushin); remainder count_next-32 (0..14) SHALL be retained left-aligned; fill = count_next-32.
REQ-015 If count_next < 32: pushout=0 next cycle and fill = count_next.
REQ-016 pushin=1 with lenin=0 SHALL change no state and SHALL NOT produce pushout.
REQ-017 There is no backpressure; at most one word SHALL be emitted per cycle, and the rule in REQ-012 makes one word per cycle sufficient.
REQ-018 flush=1 with pushin=0: if fill>0, emit held bits left-aligned, low 32-fill bits = PAD_BIT, pushout=1 next cycle, fill=0; if fill=0, no output.
REQ-019 flush=1 with pushin=1: the field SHALL be appended first.
REQ-020 Under REQ-019, if the combined count is >= 32, emit the full 32-bit word next cycle and emit the padded remainder (if non-zero) on the following cycle.
REQ-021 Under REQ-019, if the combined count is < 32, emit one padded word next cycle.
REQ-022 The internal state machine SHALL have two states: ACC and FLUSH2; FLUSH2 is entered only on the second-word case in REQ-020.
REQ-023 In FLUSH2, the padded remainder SHALL be emitted, then the state returns to ACC with fill=0.
REQ-024 In FLUSH2, a pushin in the same cycle SHALL be appended after the remainder is taken out, and behaves as in REQ-013..015 from fill=0.
REQ-025 In FLUSH2, a flush in the same cycle SHALL be ignored.
REQ-026 dataout SHALL hold its last value when pushout=0; downstream samples dataout only when pushout=1.
REQ-027 Width arithmetic SHALL be unsigned; fill SHALL never exceed 31 at a cycle boundary.

Reset
REQ-028 reset=1 at a clock edge SHALL set pushout=0, dataout=32'h0, fill=0, accumulator=0, state=ACC.
REQ-029 Reset SHALL override pushin and flush in the same cycle.
REQ-030 Reset mid-word SHALL discard the held bits without emitting them.
REQ-031 The first valid pushin SHALL be the cycle after reset deasserts.

Verification
REQ-032 Eight pushes, lenin=4, datain=1..8 on consecutive cycles -> exactly one pushout, on the cycle after the 8th push, dataout=32'h12345678, fill=0.
REQ-033 Push len15 15'h7FFF, then len15 15'h7FFF, then len2 2'b11 -> pushout one cycle after the third push, dataout=32'hFFFFFFFF, fill=0; no pushout earlier.
REQ-034 Push len15 15'h7FFF x3 (45 bits) -> word 32'hFFFFFFFF after the 3rd push, fill=13; then flush (PAD_BIT=0) -> dataout=32'hFFF80000, fill=0.
REQ-035 Push len4 4'hA together with flush -> one pushout next cycle, dataout=32'hA0000000; a further lone flush -> no pushout.
REQ-036 fill=20, then pushin len15 plus flush -> first word next cycle, padded 3-bit remainder on the following cycle, fill=0.
REQ-037 fill=20, then reset asserted one cycle, then eight len-4 pushes -> first word exactly as in REQ-032, with no stale bits.
REQ-038 lenin=0 pushes interleaved with any sequence -> output identical to the same sequence without them.
